// File: rtl/poco_mem_resp.sv
// Memory-mapped responder: single-port data RAM with a host preload port, a
// STATUS register and a TXDATA register that feeds a result FIFO streamed out
// over a valid/ready interface.
//
// Address map (CPU side):
//   addra <  2^AW   -> RAM word
//   addra == 16'hFFF0 -> STATUS (read: {0.., ovf, cnt[2:0]}, write: clear ovf)
//   addra == 16'hFFF1 -> TXDATA (write: push into result FIFO, read: 0)
//   anything else    -> unmapped (read 0, write ignored)
//
// The CPU write has priority over the host preload for the RAM write port, so
// the RAM needs only one write port. Reads are read-first.
module poco_mem_resp #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 16,
  parameter int unsigned FD = 4
) (
  input  logic          clka,
  input  logic          rsta,
  // CPU access port
  input  logic          ena,
  input  logic          wea,
  input  logic [15:0]   addra,
  input  logic [DW-1:0] dina,
  output logic [DW-1:0] douta,
  // Result stream
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  // Host preload port
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready
);

  localparam int unsigned Depth = 1 << AW;
  localparam int unsigned PtrW  = (FD > 1) ? $clog2(FD) : 1;
  localparam int unsigned CntW  = $clog2(FD + 1);

  localparam logic [15:0] AddrStatus = 16'hFFF0;
  localparam logic [15:0] AddrTxdata = 16'hFFF1;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          ram_hit;
  logic          status_hit;
  logic          tx_hit;
  logic [AW-1:0] cpu_idx;

  // RAM takes precedence so a wide AW never aliases the register addresses.
  always_comb begin
    ram_hit    = (32'(addra) < Depth);
    status_hit = !ram_hit && (addra == AddrStatus);
    tx_hit     = !ram_hit && (addra == AddrTxdata);
    cpu_idx    = AW'(addra);
  end

  // ---------------------------------------------------------------------------
  // Write qualification and arbitration
  // ---------------------------------------------------------------------------
  logic cpu_ram_we;
  logic host_we;
  logic status_wr;
  logic tx_wr;

  // Every state-changing strobe is masked by rsta so reset blocks all updates.
  always_comb begin
    cpu_ram_we = ena && wea && ram_hit && !rsta;
    ld_ready   = !rsta && !(ena && wea && ram_hit);
    host_we    = ld_valid && ld_ready;
    status_wr  = ena && wea && status_hit && !rsta;
    tx_wr      = ena && wea && tx_hit && !rsta;
  end

  // ---------------------------------------------------------------------------
  // Data RAM (not reset)
  // ---------------------------------------------------------------------------
  logic [DW-1:0] ram_q [Depth];
  logic [DW-1:0] ram_rdata;

  // Single write port; the host only gets it when the CPU is not writing RAM.
  always_ff @(posedge clka) begin
    if (cpu_ram_we) begin
      ram_q[cpu_idx] <= dina;
    end else if (host_we) begin
      ram_q[ld_addr] <= ld_data;
    end
  end

  // Read the array before the edge updates it: read-first behaviour.
  always_comb begin
    ram_rdata = ram_q[cpu_idx];
  end

  // ---------------------------------------------------------------------------
  // Result FIFO state
  // ---------------------------------------------------------------------------
  logic [DW-1:0]   fifo_q [FD];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            full;
  logic            push;
  logic            pop;
  logic            drop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FD - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Stream outputs come straight from registered state; no push bypass.
  always_comb begin
    out_valid = (cnt_q != '0) && !rsta;
    out_data  = fifo_q[rptr_q];
  end

  // Push/pop decisions; a full FIFO still accepts a push when it pops too.
  always_comb begin
    full = (cnt_q == CntW'(FD));
    pop  = out_valid && out_ready;
    push = tx_wr && (!full || pop);
    drop = tx_wr && full && !pop;
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (push) begin
      wptr_d = ptr_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (status_wr) begin
      ovf_d = 1'b0;
    end else if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // FIFO control registers with synchronous reset.
  always_ff @(posedge clka) begin
    if (rsta) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // FIFO storage; push is already masked by reset.
  always_ff @(posedge clka) begin
    if (push) begin
      fifo_q[wptr_q] <= dina;
    end
  end

  // ---------------------------------------------------------------------------
  // CPU read data
  // ---------------------------------------------------------------------------
  logic [DW-1:0] status_word;
  logic [DW-1:0] douta_q, douta_d;

  // STATUS samples the live occupancy register, so it never lags the FIFO.
  always_comb begin
    status_word      = '0;
    status_word[3]   = ovf_q;
    status_word[2:0] = 3'(cnt_q);
  end

  // Select read data; hold the previous value when no access is made.
  always_comb begin
    douta_d = douta_q;
    if (ena) begin
      if (ram_hit) begin
        douta_d = ram_rdata;
      end else if (status_hit) begin
        douta_d = status_word;
      end else begin
        douta_d = '0;
      end
    end
  end

  // Registered read port with synchronous clear.
  always_ff @(posedge clka) begin
    if (rsta) begin
      douta_q <= '0;
    end else begin
      douta_q <= douta_d;
    end
  end

  always_comb begin
    douta = douta_q;
  end

endmodule

// File: tb/tb_poco_mem_resp.sv
// Directed bench for poco_mem_resp: preload, arbitration, read-first, FIFO
// fill/overflow/drain, simultaneous push+pop and mid-stream reset.
module tb_poco_mem_resp;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16;
  localparam int unsigned FD = 4;

  localparam logic [15:0] AddrStatus = 16'hFFF0;
  localparam logic [15:0] AddrTxdata = 16'hFFF1;

  logic          clka = 1'b0;
  logic          rsta;
  logic          ena;
  logic          wea;
  logic [15:0]   addra;
  logic [DW-1:0] dina;
  logic [DW-1:0] douta;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_ready;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  poco_mem_resp #(
    .AW(AW),
    .DW(DW),
    .FD(FD)
  ) u_dut (
    .clka      (clka),
    .rsta      (rsta),
    .ena       (ena),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .douta     (douta),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready)
  );

  always #5 clka = ~clka;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clka);
    #1;
  endtask

  // One CPU access cycle; douta reflects it on return.
  task automatic cpu(input logic we, input logic [15:0] a, input logic [DW-1:0] d);
    ena   = 1'b1;
    wea   = we;
    addra = a;
    dina  = d;
    step();
    ena   = 1'b0;
    wea   = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] exp_q [$];

    rsta      = 1'b1;
    ena       = 1'b0;
    wea       = 1'b0;
    addra     = '0;
    dina      = '0;
    out_ready = 1'b0;
    ld_valid  = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;

    // Reset state
    step();
    step();
    check_eq("rst_douta", 32'(douta), 32'h0);
    check_eq("rst_out_valid", 32'(out_valid), 32'h0);
    check_eq("rst_ld_ready", 32'(ld_ready), 32'h0);
    rsta = 1'b0;
    #1;
    check_eq("ld_ready_idle", 32'(ld_ready), 32'h1);

    // Host preload word 5, CPU reads it back
    ld_valid = 1'b1;
    ld_addr  = 10'd5;
    ld_data  = 16'h1234;
    step();
    ld_valid = 1'b0;
    cpu(1'b0, 16'd5, '0);
    check_eq("preload_rd5", 32'(douta), 32'h1234);

    // Arbitration: CPU write wins, host write lands the next cycle
    ld_valid = 1'b1;
    ld_addr  = 10'd3;
    ld_data  = 16'h5555;
    ena      = 1'b1;
    wea      = 1'b1;
    addra    = 16'd3;
    dina     = 16'hAAAA;
    #1;
    check_eq("arb_ld_ready_lo", 32'(ld_ready), 32'h0);
    step();
    wea = 1'b0;
    #1;
    check_eq("arb_ld_ready_hi", 32'(ld_ready), 32'h1);
    step();  // CPU reads word 3 while the host write lands (read-first)
    ld_valid = 1'b0;
    ena      = 1'b0;
    check_eq("arb_word3_cpu", 32'(douta), 32'hAAAA);
    cpu(1'b0, 16'd3, '0);
    check_eq("arb_word3_host", 32'(douta), 32'h5555);

    // Read-first on a CPU write
    cpu(1'b1, 16'd7, 16'h0011);
    cpu(1'b1, 16'd7, 16'h00FF);
    check_eq("rf_old", 32'(douta), 32'h0011);
    cpu(1'b0, 16'd7, '0);
    check_eq("rf_new", 32'(douta), 32'h00FF);

    // Unmapped write must not alias into RAM; unmapped/TXDATA reads return 0
    cpu(1'b1, 16'd0, 16'hBEEF);
    cpu(1'b1, 16'h0400, 16'hDEAD);
    cpu(1'b0, 16'd0, '0);
    check_eq("unmap_wr_noalias", 32'(douta), 32'hBEEF);
    cpu(1'b0, 16'h0400, '0);
    check_eq("unmap_rd", 32'(douta), 32'h0);
    cpu(1'b0, 16'd0, '0);
    cpu(1'b0, AddrTxdata, '0);
    check_eq("txdata_rd", 32'(douta), 32'h0);

    // douta holds with ena low
    cpu(1'b0, 16'd5, '0);
    addra = 16'd7;
    step();
    check_eq("douta_hold", 32'(douta), 32'h1234);

    // FIFO fill with overflow, no bypass
    out_ready = 1'b0;
    check_eq("fifo_empty", 32'(out_valid), 32'h0);
    for (int i = 1; i <= 5; i++) begin
      cpu(1'b1, AddrTxdata, DW'(i));
      if (i == 1) check_eq("nobypass_valid", 32'(out_valid), 32'h1);
    end
    cpu(1'b0, AddrStatus, '0);
    check_eq("fill_status", 32'(douta), 32'h000C);
    step();
    check_eq("stall_head", 32'(out_data), 32'h1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check_eq("drain_valid", 32'(out_valid), 32'h1);
      check_eq("drain_data", 32'(out_data), 32'(i));
      step();
    end
    out_ready = 1'b0;
    check_eq("drain_empty", 32'(out_valid), 32'h0);
    cpu(1'b1, AddrStatus, 16'hFFFF);
    cpu(1'b0, AddrStatus, '0);
    check_eq("ovf_cleared", 32'(douta), 32'h0000);

    // Simultaneous push and pop on a full FIFO
    for (int i = 5; i <= 8; i++) cpu(1'b1, AddrTxdata, DW'(i));
    out_ready = 1'b1;
    cpu(1'b1, AddrTxdata, 16'd9);
    out_ready = 1'b0;
    cpu(1'b0, AddrStatus, '0);
    check_eq("simul_status", 32'(douta), 32'h0004);
    exp_q = '{16'd6, 16'd7, 16'd8, 16'd9};
    out_ready = 1'b1;
    foreach (exp_q[k]) begin
      check_eq("simul_drain", 32'(out_data), 32'(exp_q[k]));
      step();
    end
    out_ready = 1'b0;
    check_eq("simul_empty", 32'(out_valid), 32'h0);

    // Reset mid-stream
    for (int i = 1; i <= 3; i++) cpu(1'b1, AddrTxdata, DW'(16'h20 + i));
    cpu(1'b0, AddrStatus, '0);
    check_eq("pre_rst_status", 32'(douta), 32'h0003);
    cpu(1'b0, 16'd5, '0);
    rsta = 1'b1;
    #1;
    check_eq("rst_gate_valid", 32'(out_valid), 32'h0);
    step();
    rsta = 1'b0;
    check_eq("midrst_valid", 32'(out_valid), 32'h0);
    check_eq("midrst_douta", 32'(douta), 32'h0);
    cpu(1'b0, AddrStatus, '0);
    check_eq("midrst_status", 32'(douta), 32'h0000);
    cpu(1'b0, 16'd5, '0);
    check_eq("midrst_ram5", 32'(douta), 32'h1234);
    cpu(1'b0, 16'd3, '0);
    check_eq("midrst_ram3", 32'(douta), 32'h5555);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
